// File: rtl/bu_arb.sv
// bu_arb: multi-master AHB arbiter. It grants one owner, routes the owner's address phase and the
// data-phase owner's write data, and drains the last data phase on release. Macro BU_ARB_RR_EN selects round-robin.
module bu_arb #(
    parameter int  NUM_MST = 3,
    parameter int  AW      = 64,
    parameter int  DW      = 64,
    localparam int IW      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_MST-1:0]    m_bus_req,
    output logic [NUM_MST-1:0]    m_bus_ack,
    input  logic [NUM_MST*AW-1:0] m_haddr,
    input  logic [NUM_MST*DW-1:0] m_hwdata,
    input  logic [NUM_MST-1:0]    m_hwrite,
    input  logic [NUM_MST*3-1:0]  m_hsize,
    input  logic [NUM_MST*3-1:0]  m_hburst,
    input  logic [NUM_MST*4-1:0]  m_hprot,
    input  logic [NUM_MST*2-1:0]  m_htrans,
    input  logic [NUM_MST-1:0]    m_hmastlock,
    output logic [NUM_MST-1:0]    m_hready,
    output logic                  m_hresp,
    output logic [DW-1:0]         m_hrdata,
    output logic [AW-1:0]         haddr,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic [1:0]            htrans,
    output logic                  hmastlock,
    output logic [DW-1:0]         hwdata,
    input  logic                  hready,
    input  logic                  hresp,
    input  logic [DW-1:0]         hrdata,
    output logic [IW-1:0]         owner_id,
    output logic [1:0]            dbg_state
);

    // A master holds m_bus_req while it wants the bus; m_bus_ack (one-hot, registered) marks the owner,
    // and ownership is released only when both the owner's m_bus_req and m_hmastlock are low.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      dp_owner_q, dp_owner_d;
    logic               dp_valid_q, dp_valid_d;
    logic [NUM_MST-1:0] ack_q, ack_d;
    logic [IW-1:0]      sel_idx;
    logic               sel_found;
    logic [NUM_MST-1:0] sel_onehot;
    logic               owner_holds;
    logic               grant;

`ifdef BU_ARB_RR_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    int            best_dist;
    int            dist;

    // The requester closest after the last owner (wrapping) wins.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        best_dist = NUM_MST;
        dist      = 0;
        for (int i = 0; i < NUM_MST; i++) begin
            dist = i - int'(rr_ptr_q) - 1;
            if (dist < 0) dist = dist + NUM_MST;
            if (m_bus_req[i] && (dist < best_dist)) begin
                best_dist = dist;
                sel_idx   = IW'(i);
                sel_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (m_bus_req[i]) begin
                sel_idx   = IW'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        owner_holds = 1'b0;
        sel_onehot  = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (owner_q == IW'(i)) owner_holds = m_bus_req[i] | m_hmastlock[i];
            sel_onehot[i] = sel_found && (sel_idx == IW'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ack_d      = ack_q;
        dp_valid_d = dp_valid_q;
        dp_owner_d = dp_owner_q;
        grant      = 1'b0;
`ifdef BU_ARB_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        unique case (state_q)
            S_IDLE:  grant = sel_found;
            S_OWN: begin
                if (!owner_holds) begin
                    state_d = S_DRAIN;
                    ack_d   = '0;
                end
            end
            S_DRAIN: begin
                if (hready) begin
                    if (sel_found) grant = 1'b1;
                    else           state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = '0;
            end
        endcase
        if (grant) begin
            state_d = S_OWN;
            owner_d = sel_idx;
            ack_d   = sel_onehot;
`ifdef BU_ARB_RR_EN
            rr_ptr_d = sel_idx;
`endif
        end
        // Each accepted transfer moves the address-phase owner into the data phase.
        if (hready) begin
            dp_valid_d = (state_q == S_OWN);
            dp_owner_d = owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            ack_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_owner_q <= '0;
`ifdef BU_ARB_RR_EN
            rr_ptr_q   <= IW'(NUM_MST - 1);
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ack_q      <= ack_d;
            dp_valid_q <= dp_valid_d;
            dp_owner_q <= dp_owner_d;
`ifdef BU_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    always_comb begin
        haddr     = '0;
        hwrite    = 1'b0;
        hsize     = '0;
        hburst    = '0;
        hprot     = '0;
        htrans    = 2'b00;
        hmastlock = 1'b0;
        hwdata    = '0;
        m_hready  = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if ((state_q == S_OWN) && (owner_q == IW'(i))) begin
                haddr     = m_haddr[i*AW +: AW];
                hwrite    = m_hwrite[i];
                hsize     = m_hsize[i*3 +: 3];
                hburst    = m_hburst[i*3 +: 3];
                hprot     = m_hprot[i*4 +: 4];
                htrans    = m_htrans[i*2 +: 2];
                hmastlock = m_hmastlock[i];
            end
            if (dp_valid_q && (dp_owner_q == IW'(i))) begin
                hwdata      = m_hwdata[i*DW +: DW];
                m_hready[i] = hready;
            end
        end
    end

    assign m_bus_ack = ack_q;
    assign owner_id  = owner_q;
    assign dbg_state = state_q;
    assign m_hresp   = hresp;
    assign m_hrdata  = hrdata;

endmodule

// File: tb/tb_bu_arb.sv
// Directed bench for bu_arb: table of per-cycle vectors for a 3-master instance plus hand sequences
// for reset mid-transfer, arbitration order, and a 5-master instance.
`timescale 1ns/1ps
module tb_bu_arb;
    localparam int N3  = 3;
    localparam int AW3 = 64;
    localparam int DW3 = 64;
    localparam int N5  = 5;
    localparam int AW5 = 32;
    localparam int DW5 = 32;
    localparam logic [63:0] A_BASE = 64'hA000_0000_0000_0000;
    localparam logic [63:0] D_BASE = 64'hD000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 3-master instance
    logic [N3-1:0]     m_bus_req, m_bus_ack, m_hwrite, m_hmastlock, m_hready;
    logic [N3*AW3-1:0] m_haddr;
    logic [N3*DW3-1:0] m_hwdata;
    logic [N3*3-1:0]   m_hsize, m_hburst;
    logic [N3*4-1:0]   m_hprot;
    logic [N3*2-1:0]   m_htrans;
    logic              m_hresp, hwrite, hmastlock, hready, hresp;
    logic [DW3-1:0]    m_hrdata, hwdata, hrdata;
    logic [AW3-1:0]    haddr;
    logic [2:0]        hsize, hburst;
    logic [3:0]        hprot;
    logic [1:0]        htrans, dbg_state;
    logic [1:0]        owner_id;

    // 5-master instance
    logic [N5-1:0]     r5_req, r5_ack, r5_hwrite, r5_lock, r5_mhready;
    logic [N5*AW5-1:0] r5_haddr_in;
    logic [N5*DW5-1:0] r5_hwdata_in;
    logic [N5*3-1:0]   r5_hsize_in, r5_hburst_in;
    logic [N5*4-1:0]   r5_hprot_in;
    logic [N5*2-1:0]   r5_htrans_in;
    logic              r5_mhresp, r5_hwrite_out, r5_hmastlock_out, r5_hready, r5_hresp;
    logic [DW5-1:0]    r5_mhrdata, r5_hwdata_out, r5_hrdata;
    logic [AW5-1:0]    r5_haddr_out;
    logic [2:0]        r5_hsize_out, r5_hburst_out;
    logic [3:0]        r5_hprot_out;
    logic [1:0]        r5_htrans_out, r5_state;
    logic [2:0]        r5_owner;

    bu_arb #(.NUM_MST(N3), .AW(AW3), .DW(DW3)) dut3 (
        .clk(clk), .rst(rst), .m_bus_req(m_bus_req), .m_bus_ack(m_bus_ack),
        .m_haddr(m_haddr), .m_hwdata(m_hwdata), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hmastlock(m_hmastlock),
        .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .owner_id(owner_id), .dbg_state(dbg_state)
    );

    bu_arb #(.NUM_MST(N5), .AW(AW5), .DW(DW5)) dut5 (
        .clk(clk), .rst(rst), .m_bus_req(r5_req), .m_bus_ack(r5_ack),
        .m_haddr(r5_haddr_in), .m_hwdata(r5_hwdata_in), .m_hwrite(r5_hwrite), .m_hsize(r5_hsize_in),
        .m_hburst(r5_hburst_in), .m_hprot(r5_hprot_in), .m_htrans(r5_htrans_in), .m_hmastlock(r5_lock),
        .m_hready(r5_mhready), .m_hresp(r5_mhresp), .m_hrdata(r5_mhrdata),
        .haddr(r5_haddr_out), .hwrite(r5_hwrite_out), .hsize(r5_hsize_out), .hburst(r5_hburst_out),
        .hprot(r5_hprot_out), .htrans(r5_htrans_out), .hmastlock(r5_hmastlock_out), .hwdata(r5_hwdata_out),
        .hready(r5_hready), .hresp(r5_hresp), .hrdata(r5_hrdata),
        .owner_id(r5_owner), .dbg_state(r5_state)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs applied before an edge; expected registered state after it. dp = 3 means no data-phase owner.
    typedef struct {
        logic [2:0] req;
        logic [2:0] lock;
        logic       hrdy;
        logic [2:0] ack;
        logic [1:0] st;
        logic [1:0] own;
        logic [1:0] dp;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    logic [63:0] exp_addr, exp_wdata;
    logic [2:0]  exp_rdy;
    int          exp_seq[4];
    int          n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b000, 3'b000, 1'b1, 3'b000, 2'd0, 2'd0, 2'd3};
        vecs[1]  = '{3'b000, 3'b000, 1'b1, 3'b000, 2'd0, 2'd0, 2'd3};
        vecs[2]  = '{3'b001, 3'b000, 1'b1, 3'b001, 2'd1, 2'd0, 2'd3};
        vecs[3]  = '{3'b001, 3'b000, 1'b1, 3'b001, 2'd1, 2'd0, 2'd0};
        vecs[4]  = '{3'b000, 3'b000, 1'b1, 3'b000, 2'd2, 2'd0, 2'd0};
        vecs[5]  = '{3'b000, 3'b000, 1'b1, 3'b000, 2'd0, 2'd0, 2'd3};
        vecs[6]  = '{3'b010, 3'b000, 1'b1, 3'b010, 2'd1, 2'd1, 2'd3};
        vecs[7]  = '{3'b010, 3'b000, 1'b1, 3'b010, 2'd1, 2'd1, 2'd1};
        vecs[8]  = '{3'b100, 3'b000, 1'b0, 3'b000, 2'd2, 2'd1, 2'd1};
        vecs[9]  = '{3'b100, 3'b000, 1'b0, 3'b000, 2'd2, 2'd1, 2'd1};
        vecs[10] = '{3'b100, 3'b000, 1'b0, 3'b000, 2'd2, 2'd1, 2'd1};
        vecs[11] = '{3'b100, 3'b000, 1'b1, 3'b100, 2'd1, 2'd2, 2'd3};
        vecs[12] = '{3'b100, 3'b000, 1'b1, 3'b100, 2'd1, 2'd2, 2'd2};
        vecs[13] = '{3'b000, 3'b000, 1'b1, 3'b000, 2'd2, 2'd2, 2'd2};
        vecs[14] = '{3'b001, 3'b000, 1'b1, 3'b001, 2'd1, 2'd0, 2'd3};
        vecs[15] = '{3'b001, 3'b001, 1'b1, 3'b001, 2'd1, 2'd0, 2'd0};
        vecs[16] = '{3'b100, 3'b001, 1'b1, 3'b001, 2'd1, 2'd0, 2'd0};
        vecs[17] = '{3'b100, 3'b001, 1'b1, 3'b001, 2'd1, 2'd0, 2'd0};
        vecs[18] = '{3'b100, 3'b000, 1'b1, 3'b000, 2'd2, 2'd0, 2'd0};
        vecs[19] = '{3'b100, 3'b000, 1'b1, 3'b100, 2'd1, 2'd2, 2'd3};
        vecs[20] = '{3'b110, 3'b000, 1'b1, 3'b100, 2'd1, 2'd2, 2'd2};
        vecs[21] = '{3'b010, 3'b000, 1'b1, 3'b000, 2'd2, 2'd2, 2'd2};
        vecs[22] = '{3'b010, 3'b000, 1'b1, 3'b010, 2'd1, 2'd1, 2'd3};

`ifdef BU_ARB_RR_EN
        exp_seq = '{0, 1, 2, 0};
`else
        exp_seq = '{0, 0, 0, 0};
`endif

        for (int i = 0; i < N3; i++) begin
            m_haddr[i*AW3 +: AW3]  = A_BASE + 64'(i);
            m_hwdata[i*DW3 +: DW3] = D_BASE + 64'(i);
            m_hsize[i*3 +: 3]      = 3'b011;
            m_hburst[i*3 +: 3]     = 3'b001;
            m_hprot[i*4 +: 4]      = 4'b0011;
            m_htrans[i*2 +: 2]     = 2'b10;
        end
        m_hwrite = '1;
        for (int i = 0; i < N5; i++) begin
            r5_haddr_in[i*AW5 +: AW5]  = 32'hA500_0000 + 32'(i);
            r5_hwdata_in[i*DW5 +: DW5] = 32'hD500_0000 + 32'(i);
            r5_hsize_in[i*3 +: 3]      = 3'b010;
            r5_hburst_in[i*3 +: 3]     = 3'b000;
            r5_hprot_in[i*4 +: 4]      = 4'b0001;
            r5_htrans_in[i*2 +: 2]     = 2'b10;
        end
        r5_hwrite = '0;
        r5_req    = '0;
        r5_lock   = '0;
        r5_hready = 1'b1;
        r5_hresp  = 1'b0;
        r5_hrdata = 32'h1234_5678;

        // Reset with requests present: they must be ignored.
        rst         = 1'b1;
        m_bus_req   = 3'b111;
        m_hmastlock = '0;
        hready      = 1'b1;
        hresp       = 1'b0;
        hrdata      = '0;
        repeat (3) step();
        chk("rst_ack", m_bus_ack, 3'b000);
        chk("rst_state", dbg_state, 2'd0);
        chk("rst_owner", owner_id, 2'd0);
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_haddr", haddr, 64'd0);
        chk("rst_hwdata", hwdata, 64'd0);
        chk("rst_hready", m_hready, 3'b000);
        rst       = 1'b0;
        m_bus_req = 3'b000;

        for (int v = 0; v < NV; v++) begin
            m_bus_req   = vecs[v].req;
            m_hmastlock = vecs[v].lock;
            hready      = vecs[v].hrdy;
            hrdata      = {$urandom, $urandom};
            hresp       = 1'($urandom_range(0, 1));
            step();
            exp_addr  = (vecs[v].st == 2'd1) ? (A_BASE + 64'(vecs[v].own)) : 64'd0;
            exp_wdata = (vecs[v].dp != 2'd3) ? (D_BASE + 64'(vecs[v].dp)) : 64'd0;
            exp_rdy   = (vecs[v].dp != 2'd3 && vecs[v].hrdy) ? 3'(1 << vecs[v].dp) : 3'b000;
            chk($sformatf("v%0d_ack", v), m_bus_ack, vecs[v].ack);
            chk($sformatf("v%0d_state", v), dbg_state, vecs[v].st);
            if (vecs[v].ack != 3'b000) chk($sformatf("v%0d_owner", v), owner_id, vecs[v].own);
            chk($sformatf("v%0d_haddr", v), haddr, exp_addr);
            chk($sformatf("v%0d_htrans", v), htrans, (vecs[v].st == 2'd1) ? 2'b10 : 2'b00);
            chk($sformatf("v%0d_hwrite", v), hwrite, vecs[v].st == 2'd1);
            chk($sformatf("v%0d_hwdata", v), hwdata, exp_wdata);
            chk($sformatf("v%0d_mhready", v), m_hready, exp_rdy);
            chk($sformatf("v%0d_hrdata", v), m_hrdata, hrdata);
            chk($sformatf("v%0d_hresp", v), m_hresp, hresp);
        end

        // Reset while master 1 owns the bus with a data phase in flight.
        m_bus_req = 3'b010;
        hready    = 1'b1;
        step();
        chk("pre_rst_mhready", m_hready, 3'b010);
        rst = 1'b1;
        step();
        chk("midrst_ack", m_bus_ack, 3'b000);
        chk("midrst_htrans", htrans, 2'b00);
        chk("midrst_mhready", m_hready, 3'b000);
        chk("midrst_state", dbg_state, 2'd0);
        chk("midrst_hwdata", hwdata, 64'd0);
        chk("midrst_owner", owner_id, 2'd0);
        m_bus_req = 3'b111;
        step();
        chk("rst_req_ignored", m_bus_ack, 3'b000);
        rst       = 1'b0;
        m_bus_req = 3'b000;
        step();

        // All three request; each owner releases after one transfer and re-requests once draining.
        m_bus_req = 3'b111;
        hready    = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (m_bus_ack == 3'b000 && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("arb%0d_ack", g), m_bus_ack, 3'(1 << exp_seq[g]));
            chk($sformatf("arb%0d_owner", g), owner_id, 2'(exp_seq[g]));
            step();
            m_bus_req = 3'b111 & ~3'(1 << exp_seq[g]);
            step();
            chk($sformatf("arb%0d_drain", g), dbg_state, 2'd2);
            m_bus_req = 3'b111;
        end
        m_bus_req = 3'b000;

        // Five masters: the highest index alone.
        r5_req    = 5'b10000;
        r5_hready = 1'b1;
        step();
        chk("m5_ack", r5_ack, 5'b10000);
        chk("m5_owner", r5_owner, 3'd4);
        chk("m5_haddr", r5_haddr_out, 32'hA500_0004);
        chk("m5_mhready_first", r5_mhready, 5'b00000);
        step();
        chk("m5_mhready_hi", r5_mhready, 5'b10000);
        chk("m5_hwdata", r5_hwdata_out, 32'hD500_0004);
        r5_hready = 1'b0;
        #1;
        chk("m5_mhready_lo", r5_mhready, 5'b00000);
        r5_hready = 1'b1;
        #1;
        chk("m5_mhready_back", r5_mhready, 5'b10000);
        chk("m5_hrdata", r5_mhrdata, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
